// File: rtl/sched_pkg.sv
// sched_pkg: shared state encoding and watchdog default for exec_scheduler.
package sched_pkg;
    typedef enum logic [1:0] {IDLE, DISPATCH, BUSY, RECONF} state_t;
    localparam int WDT_CYCLES_DEF = 1024;
endpackage

// File: rtl/exec_scheduler_if.sv
// exec_scheduler_if: requester, executor and reconfiguration signals of exec_scheduler.
interface exec_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8
);
    localparam int SW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]             req_valid_i;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_op_i;
    logic [NUM_REQ-1:0]             req_ready_o;
    logic                           start_o;
    logic [ADDR_W-1:0]              op_start_cnt_o;
    logic [SW-1:0]                  sel_o;
    logic                           exec_done_i;
    logic                           done_o;
    logic [SW-1:0]                  done_port_o;
    logic                           mod_req_i;
    logic                           mod_start_o;
    logic                           mod_ack_o;
    logic                           timeout_o;
    modport master (
        output req_valid_i, req_op_i, exec_done_i, mod_req_i,
        input  req_ready_o, start_o, op_start_cnt_o, sel_o, done_o, done_port_o,
               mod_start_o, mod_ack_o, timeout_o
    );
    modport slave (
        input  req_valid_i, req_op_i, exec_done_i, mod_req_i,
        output req_ready_o, start_o, op_start_cnt_o, sel_o, done_o, done_port_o,
               mod_start_o, mod_ack_o, timeout_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from last+1 with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int SW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [SW-1:0]      last,
    output logic [SW-1:0]      gnt,
    output logic               any
);
    // Descending scan so the closest requester after last is written last and wins.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (valid[SW'((int'(last) + i) % NUM_REQ)]) begin
                gnt = SW'((int'(last) + i) % NUM_REQ);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/exec_scheduler.sv
// exec_scheduler: round-robin packet dispatch to one executor with reconfig priority.
// Optional watchdog abort on a stalled executor is enabled by defining EXEC_SCHED_WDT_EN.
module exec_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 8,
    parameter int WDT_CYCLES = WDT_CYCLES_DEF,
    localparam int SW = $clog2(NUM_REQ)
) (
    input logic clk,
    input logic rst,
    exec_scheduler_if.slave bus
);
    state_t            state, nxt;
    logic [SW-1:0]     g, last, arb_g;
    logic              arb_any, done, wdt_hit;
    logic [ADDR_W-1:0] op_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid(bus.req_valid_i),
        .last (last),
        .gnt  (arb_g),
        .any  (arb_any)
    );

`ifdef EXEC_SCHED_WDT_EN
    localparam int WW = $clog2(WDT_CYCLES);
    logic [WW-1:0] wdt;
    always_ff @(posedge clk)
        wdt <= (rst || state != BUSY) ? '0 : wdt + 1'b1;
    assign wdt_hit = state == BUSY && wdt == WW'(WDT_CYCLES - 1);
`else
    assign wdt_hit = 1'b0;
`endif

    // Outputs are gated by rst so everything reads 0 while reset is held.
    always_comb begin
        nxt                = state;
        done               = 1'b0;
        bus.req_ready_o    = '0;
        bus.start_o        = 1'b0;
        bus.mod_start_o    = 1'b0;
        bus.mod_ack_o      = 1'b0;
        bus.timeout_o      = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (bus.mod_req_i) nxt = RECONF;
                    else if (arb_any) begin
                        nxt = DISPATCH;
                        bus.req_ready_o[arb_g] = 1'b1;
                    end
                end
                DISPATCH: begin
                    bus.start_o = 1'b1;
                    nxt         = BUSY;
                end
                BUSY: begin
                    if (bus.exec_done_i || wdt_hit) begin
                        done          = 1'b1;
                        bus.timeout_o = !bus.exec_done_i;
                        nxt           = IDLE;
                    end
                end
                RECONF: begin
                    bus.mod_start_o = 1'b1;
                    bus.mod_ack_o   = 1'b1;
                    nxt             = IDLE;
                end
                default: nxt = IDLE;
            endcase
        end
        bus.done_o         = done;
        bus.done_port_o    = done ? g : '0;
        bus.op_start_cnt_o = bus.start_o ? op_q : '0;
        bus.sel_o          = g;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            g     <= '0;
            last  <= SW'(NUM_REQ - 1);
            op_q  <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && nxt == DISPATCH) begin
                g    <= arb_g;
                op_q <= bus.req_op_i[arb_g];
            end
            if (done) last <= g;
        end
    end
endmodule
